// File: rtl/debounce_bank.sv
// debounce_bank: N-channel switch debouncer, one 4-state FSM per channel.
// Ports: clk; rst (async, active-low); tick (sample enable); din[N] (raw);
//   db[N] (debounced); rise/fall[N] (1-clk edge pulses);
//   pending[N] (channel is confirming a change).
// Option: define DEBOUNCE_BANK_SYNC_EN to put a 2-flop synchronizer
//   (always clocked, reset to INIT) in front of the FSMs.
module debounce_bank #(
  parameter int           N      = 10,
  parameter int           WINDOW = 100,
  parameter logic [N-1:0] INIT   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] din,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] pending
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] C_WIN = CW'(WINDOW);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {
    ZERO       = 2'b00,
    MAYBE_ONE  = 2'b01,
    ONE        = 2'b11,
    MAYBE_ZERO = 2'b10
  } state_t;

  function automatic state_t stable(input logic b);
    return b ? ONE : ZERO;
  endfunction

  logic [N-1:0] w_s;

`ifdef DEBOUNCE_BANK_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  // Synchronizer runs every clk so that tick gating never
  // stretches its latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= INIT;
      r_sync2 <= INIT;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = din;
`endif

  state_t        r_state [N];
  logic [CW-1:0] r_cnt   [N];
  logic [N-1:0]  r_db;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic [N-1:0]  r_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= stable(INIT[i]);
        r_cnt[i]   <= '0;
      end
      r_db   <= INIT;
      r_rise <= '0;
      r_fall <= '0;
      r_pend <= '0;
    end else begin
      // Pulses clear every clk, independent of tick.
      r_rise <= '0;
      r_fall <= '0;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          case (r_state[i])
            ZERO: begin
              if (w_s[i]) begin
                r_state[i] <= MAYBE_ONE;
                r_cnt[i]   <= C_ONE;
                r_pend[i]  <= 1'b1;
              end
            end
            MAYBE_ONE: begin
              if (w_s[i]) begin
                if (r_cnt[i] == C_WIN) begin
                  r_state[i] <= ONE;
                  r_cnt[i]   <= '0;
                  r_db[i]    <= 1'b1;
                  r_rise[i]  <= 1'b1;
                  r_pend[i]  <= 1'b0;
                end else begin
                  r_cnt[i] <= r_cnt[i] + C_ONE;
                end
              end else begin
                r_state[i] <= ZERO;
                r_cnt[i]   <= '0;
                r_pend[i]  <= 1'b0;
              end
            end
            ONE: begin
              if (!w_s[i]) begin
                r_state[i] <= MAYBE_ZERO;
                r_cnt[i]   <= C_ONE;
                r_pend[i]  <= 1'b1;
              end
            end
            MAYBE_ZERO: begin
              if (!w_s[i]) begin
                if (r_cnt[i] == C_WIN) begin
                  r_state[i] <= ZERO;
                  r_cnt[i]   <= '0;
                  r_db[i]    <= 1'b0;
                  r_fall[i]  <= 1'b1;
                  r_pend[i]  <= 1'b0;
                end else begin
                  r_cnt[i] <= r_cnt[i] + C_ONE;
                end
              end else begin
                r_state[i] <= ONE;
                r_cnt[i]   <= '0;
                r_pend[i]  <= 1'b0;
              end
            end
            default: begin
              r_state[i] <= stable(INIT[i]);
              r_cnt[i]   <= '0;
              r_db[i]    <= INIT[i];
              r_pend[i]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign db      = r_db;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign pending = r_pend;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed + random checks of debounce_bank
// against a run-length reference model (N=4, WINDOW=4).
module tb_debounce_bank;

  localparam int N = 4;
  localparam int W = 4;
  localparam logic [3:0] INIT = 4'b1000;
`ifdef DEBOUNCE_BANK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] din;
  logic [3:0] db;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] pending;

  int nchk = 0;
  int nerr = 0;

  // Reference model: consecutive-sample run length per channel.
  logic [3:0] mdb, mrise, mfall, mpend, ms1, ms2;
  int run [4];

  debounce_bank #(
    .N(N),
    .WINDOW(W),
    .INIT(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .din(din),
    .db(db),
    .rise(rise),
    .fall(fall),
    .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    mdb   = INIT;
    mrise = '0;
    mfall = '0;
    mpend = '0;
    ms1   = INIT;
    ms2   = INIT;
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    s = (LAT != 0) ? ms2 : din;
    ms2 = ms1;
    ms1 = din;
    mrise = '0;
    mfall = '0;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (s[i] != mdb[i]) begin
          run[i]++;
          if (run[i] == W + 1) begin
            mdb[i]   = s[i];
            mrise[i] = s[i];
            mfall[i] = ~s[i];
            run[i]   = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) mpend[i] = (run[i] != 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic do_reset();
    din  = INIT;
    tick = 1'b1;
    rst  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    din  = INIT;
    tick = 1'b1;
    rst  = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    nchk++;
    if ({db, rise, fall, pending} !== {INIT, 12'h000}) begin
      nerr++;
      $display("FAIL reset_async got db=%b r=%b f=%b p=%b want db=%b r=0 f=0 p=0",
               db, rise, fall, pending, INIT);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      nchk++;
      if ({db, rise, fall, pending} !== {INIT, 12'h000}) begin
        nerr++;
        $display("FAIL reset_held k=%0d got db=%b r=%b f=%b p=%b want db=%b",
                 k, db, rise, fall, pending, INIT);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      nchk++;
      if ({db, rise, fall, pending} !== {INIT, 12'h000}) begin
        nerr++;
        $display("FAIL reset_idle k=%0d got db=%b r=%b f=%b p=%b want db=%b",
                 k, db, rise, fall, pending, INIT);
      end
    end
  endtask

  task automatic test_single_rise();
    logic [3:0] ed, er, ep;
    do_reset();
    cyc();
    din = INIT | 4'b0001;
    for (int t = 0; t <= LAT + 5; t++) begin
      cyc();
      ed = (t >= LAT + 4) ? 4'b1001 : 4'b1000;
      er = (t == LAT + 4) ? 4'b0001 : 4'b0000;
      ep = (t >= LAT && t < LAT + 4) ? 4'b0001 : 4'b0000;
      nchk++;
      if ({db, rise, fall, pending} !== {ed, er, 4'b0000, ep}) begin
        nerr++;
        $display("FAIL single_rise t=%0d got db=%b r=%b f=%b p=%b want db=%b r=%b f=0000 p=%b",
                 t, db, rise, fall, pending, ed, er, ep);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] ep;
    do_reset();
    cyc();
    for (int t = 0; t <= LAT + 5; t++) begin
      din = (t < 3) ? 4'b1010 : 4'b1000;
      cyc();
      ep = (t >= LAT && t < LAT + 3) ? 4'b0010 : 4'b0000;
      nchk++;
      if ({db, rise, fall, pending} !== {INIT, 8'h00, ep}) begin
        nerr++;
        $display("FAIL glitch t=%0d got db=%b r=%b f=%b p=%b want db=%b r=0000 f=0000 p=%b",
                 t, db, rise, fall, pending, INIT, ep);
      end
    end
  endtask

  task automatic test_slow_tick();
    logic [3:0] ed, er, ep;
    do_reset();
    din = INIT | 4'b0100;
    for (int c = 0; c <= 16; c++) begin
      tick = (c % 3 == 2);
      cyc();
      ed = (c >= 14) ? 4'b1100 : 4'b1000;
      er = (c == 14) ? 4'b0100 : 4'b0000;
      ep = (c >= 2 && c < 14) ? 4'b0100 : 4'b0000;
      nchk++;
      if ({db, rise, fall, pending} !== {ed, er, 4'b0000, ep}) begin
        nerr++;
        $display("FAIL slow_tick c=%0d got db=%b r=%b f=%b p=%b want db=%b r=%b f=0000 p=%b",
                 c, db, rise, fall, pending, ed, er, ep);
      end
    end
    tick = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [3:0] ed, er, ef, ep;
    do_reset();
    cyc();
    din = 4'b0100;
    for (int t = 0; t <= LAT + 5; t++) begin
      cyc();
      ed = (t >= LAT + 4) ? 4'b0100 : 4'b1000;
      er = (t == LAT + 4) ? 4'b0100 : 4'b0000;
      ef = (t == LAT + 4) ? 4'b1000 : 4'b0000;
      ep = (t >= LAT && t < LAT + 4) ? 4'b1100 : 4'b0000;
      nchk++;
      if ({db, rise, fall, pending} !== {ed, er, ef, ep}) begin
        nerr++;
        $display("FAIL simultaneous t=%0d got db=%b r=%b f=%b p=%b want db=%b r=%b f=%b p=%b",
                 t, db, rise, fall, pending, ed, er, ef, ep);
      end
    end
  endtask

  task automatic test_reset_mid_maybe();
    logic [3:0] ed, er, ep;
    do_reset();
    cyc();
    din = 4'b1001;
    repeat (LAT + 2) cyc();
    nchk++;
    if (pending !== 4'b0001) begin
      nerr++;
      $display("FAIL mid_pending got p=%b want p=0001", pending);
    end
    rst = 1'b0;
    model_reset();
    #1;
    nchk++;
    if ({db, rise, fall, pending} !== {INIT, 12'h000}) begin
      nerr++;
      $display("FAIL mid_reset got db=%b r=%b f=%b p=%b want db=%b r=0 f=0 p=0",
               db, rise, fall, pending, INIT);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      nchk++;
      if ({db, rise, fall, pending} !== {INIT, 12'h000}) begin
        nerr++;
        $display("FAIL mid_reset_hold k=%0d got db=%b r=%b f=%b p=%b want db=%b",
                 k, db, rise, fall, pending, INIT);
      end
    end
    rst = 1'b1;
    for (int t = 0; t <= LAT + 5; t++) begin
      cyc();
      ed = (t >= LAT + 4) ? 4'b1001 : 4'b1000;
      er = (t == LAT + 4) ? 4'b0001 : 4'b0000;
      ep = (t >= LAT && t < LAT + 4) ? 4'b0001 : 4'b0000;
      nchk++;
      if ({db, rise, fall, pending} !== {ed, er, 4'b0000, ep}) begin
        nerr++;
        $display("FAIL after_reset t=%0d got db=%b r=%b f=%b p=%b want db=%b r=%b f=0000 p=%b",
                 t, db, rise, fall, pending, ed, er, ep);
      end
    end
  endtask

  task automatic test_random();
    int pct;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      pct  = (n < 1500) ? 9 : 39;
      tick = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, pct) == 0) din[i] = ~din[i];
      end
      cyc();
      nchk++;
      if ({db, rise, fall, pending} !== {mdb, mrise, mfall, mpend}) begin
        nerr++;
        $display("FAIL random n=%0d got db=%b r=%b f=%b p=%b want db=%b r=%b f=%b p=%b",
                 n, db, rise, fall, pending, mdb, mrise, mfall, mpend);
      end
    end
    tick = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_slow_tick();
    test_simultaneous();
    test_reset_mid_maybe();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
